// File: rtl/mips_pkg.sv
// Shared op codes and FSM states for the iterative multiply/divide unit.
// No timing of its own; the busy/done handshake lives in mips_muldiv.
package mips_pkg;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/mips_muldiv_if.sv
// Decode-stage request and HI/LO result bundle for mips_muldiv.
// Requests are accepted only while busy is low; done is a one-cycle pulse.
interface mips_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fix.
// Purely combinational; no handshake.
module muldiv_negate #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] in_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] out_o
);

    assign out_o = neg_i ? (~in_i + WIDTH'(1)) : in_i;

endmodule

// File: rtl/mips_muldiv.sv
// Iterative radix-2 multiply / restoring divide with HI/LO; WIDTH+1 cycles busy, done pulse after.
// start is ignored while busy; flush squashes the operation in flight without touching HI/LO.
module mips_muldiv
    import mips_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    mips_muldiv_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     opr_q, opr_d;
    logic                 is_mul_q, is_mul_d;
    logic                 negp_q, negp_d;
    logic                 negr_q, negr_d;
    logic                 divz_q, divz_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
    logic                 done_q, done_d;

    logic                 sign_op;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    assign sign_op = (bus.op == OP_MULT) || (bus.op == OP_DIV);

    muldiv_negate #(.WIDTH(WIDTH)) u_abs_a (
        .in_i  (bus.a),
        .neg_i (sign_op & bus.a[WIDTH-1]),
        .out_o (abs_a)
    );

    muldiv_negate #(.WIDTH(WIDTH)) u_abs_b (
        .in_i  (bus.b),
        .neg_i (sign_op & bus.b[WIDTH-1]),
        .out_o (abs_b)
    );

    muldiv_negate #(.WIDTH(2*WIDTH)) u_fix_prod (
        .in_i  (acc_q),
        .neg_i (negp_q),
        .out_o (prod_fix)
    );

    // Division by zero keeps the all-ones quotient regardless of operand signs.
    muldiv_negate #(.WIDTH(WIDTH)) u_fix_quo (
        .in_i  (acc_q[WIDTH-1:0]),
        .neg_i (negp_q & ~divz_q),
        .out_o (quo_fix)
    );

    muldiv_negate #(.WIDTH(WIDTH)) u_fix_rem (
        .in_i  (acc_q[2*WIDTH-1:WIDTH]),
        .neg_i (negr_q),
        .out_o (rem_fix)
    );

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each cycle.
    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_next;
    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? opr_q : {WIDTH{1'b0}})};
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; the extra bit of div_part holds the borrow.
    logic [WIDTH:0]       div_part, div_diff;
    logic                 qbit;
    logic [WIDTH-1:0]     rem_new;
    logic [2*WIDTH-1:0]   div_next;
    assign div_part = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign div_diff = div_part - {1'b0, opr_q};
    assign qbit     = ~div_diff[WIDTH];
    assign rem_new  = qbit ? div_diff[WIDTH-1:0] : div_part[WIDTH-1:0];
    assign div_next = {rem_new, acc_q[WIDTH-2:0], qbit};

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opr_d    = opr_q;
        is_mul_d = is_mul_q;
        negp_d   = negp_q;
        negr_d   = negr_q;
        divz_d   = divz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            state_d  = S_CALC;
                            cnt_d    = '0;
                            acc_d    = {{WIDTH{1'b0}}, abs_b};
                            opr_d    = abs_a;
                            is_mul_d = 1'b1;
                            negp_d   = sign_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            negr_d   = sign_op & bus.a[WIDTH-1];
                            divz_d   = 1'b0;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d  = S_CALC;
                            cnt_d    = '0;
                            acc_d    = {{WIDTH{1'b0}}, abs_a};
                            opr_d    = abs_b;
                            is_mul_d = 1'b0;
                            negp_d   = sign_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            negr_d   = sign_op & bus.a[WIDTH-1];
                            divz_d   = (bus.b == '0);
                        end
                        OP_MTHI: begin
                            hi_d   = bus.a;
                            done_d = 1'b1;
                        end
                        OP_MTLO: begin
                            lo_d   = bus.a;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            S_CALC: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = is_mul_q ? mul_next : div_next;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_FIX;
                    end
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!bus.flush) begin
                    done_d = 1'b1;
                    if (is_mul_q) begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            opr_q    <= '0;
            is_mul_q <= 1'b0;
            negp_q   <= 1'b0;
            negr_q   <= 1'b0;
            divz_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opr_q    <= opr_d;
            is_mul_q <= is_mul_d;
            negp_q   <= negp_d;
            negr_q   <= negr_d;
            divz_q   <= divz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed bench for mips_muldiv at WIDTH=32: latency, signed/unsigned results,
// divide corner cases, mthi/mtlo, start-while-busy, flush and mid-operation reset.
module tb_mips_muldiv;
    import mips_pkg::*;

    localparam int W = 32;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    mips_muldiv_if #(.WIDTH(W)) bus_if ();

    mips_muldiv #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle 1 time unit after it.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Request an operation; returns just after the accepting edge with start cleared.
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus_if.op    = op;
        bus_if.a     = a;
        bus_if.b     = b;
        bus_if.start = 1'b1;
        cyc();
        bus_if.start = 1'b0;
    endtask

    // Count edges until done; busy samples include the one already visible on entry.
    task automatic run_to_done(output int cycles, output int busy_cnt);
        cycles   = 0;
        busy_cnt = bus_if.busy ? 1 : 0;
        while (cycles < 100) begin
            cyc();
            cycles++;
            if (bus_if.done) break;
            if (bus_if.busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        cyc();
        cyc();
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus_if.busy); end
        checks++; if (bus_if.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus_if.done); end
        checks++; if (bus_if.hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", bus_if.hi); end
        checks++; if (bus_if.lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", bus_if.lo); end
        reset = 1'b1;
        cyc();
    endtask

    task automatic test_multu_latency();
        int n, nb;
        issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        checks++; if (bus_if.busy !== 1'b1) begin errors++; $display("FAIL multu_busy_rise: got %b want 1", bus_if.busy); end
        run_to_done(n, nb);
        checks++; if (n !== 33) begin errors++; $display("FAIL multu_latency: got %0d want 33", n); end
        checks++; if (nb !== 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 33", nb); end
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL multu_busy_at_done: got %b want 0", bus_if.busy); end
        checks++; if (bus_if.hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", bus_if.hi); end
        checks++; if (bus_if.lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", bus_if.lo); end
        cyc();
        checks++; if (bus_if.done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b want 0", bus_if.done); end
    endtask

    task automatic test_signed();
        int n, nb;
        issue(OP_MULT, 32'hFFFF_FFFD, 32'd5);
        run_to_done(n, nb);
        checks++; if (n !== 33) begin errors++; $display("FAIL mult_latency: got %0d want 33", n); end
        checks++; if (bus_if.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", bus_if.hi); end
        checks++; if (bus_if.lo !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo: got %h want fffffff1", bus_if.lo); end
        issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
        run_to_done(n, nb);
        checks++; if (bus_if.lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_lo: got %h want fffffffd", bus_if.lo); end
        checks++; if (bus_if.hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_hi: got %h want ffffffff", bus_if.hi); end
    endtask

    task automatic test_div_edges();
        int n, nb;
        issue(OP_DIVU, 32'd7, 32'd0);
        run_to_done(n, nb);
        checks++; if (n !== 33) begin errors++; $display("FAIL divz_latency: got %0d want 33", n); end
        checks++; if (bus_if.lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_lo: got %h want ffffffff", bus_if.lo); end
        checks++; if (bus_if.hi !== 32'h0000_0007) begin errors++; $display("FAIL divz_hi: got %h want 00000007", bus_if.hi); end
        issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        run_to_done(n, nb);
        checks++; if (bus_if.lo !== 32'h8000_0000) begin errors++; $display("FAIL divmin_lo: got %h want 80000000", bus_if.lo); end
        checks++; if (bus_if.hi !== 32'h0000_0000) begin errors++; $display("FAIL divmin_hi: got %h want 00000000", bus_if.hi); end
    endtask

    task automatic test_mthi_mtlo();
        bus_if.op    = OP_MTHI;
        bus_if.a     = 32'h0000_1234;
        bus_if.start = 1'b1;
        cyc();
        bus_if.op = OP_MTLO;
        bus_if.a  = 32'h0000_5678;
        checks++; if (bus_if.done !== 1'b1) begin errors++; $display("FAIL mthi_done: got %b want 1", bus_if.done); end
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL mthi_busy: got %b want 0", bus_if.busy); end
        checks++; if (bus_if.hi !== 32'h0000_1234) begin errors++; $display("FAIL mthi_hi: got %h want 00001234", bus_if.hi); end
        cyc();
        bus_if.start = 1'b0;
        checks++; if (bus_if.done !== 1'b1) begin errors++; $display("FAIL mtlo_done: got %b want 1", bus_if.done); end
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL mtlo_busy: got %b want 0", bus_if.busy); end
        checks++; if (bus_if.lo !== 32'h0000_5678) begin errors++; $display("FAIL mtlo_lo: got %h want 00005678", bus_if.lo); end
        checks++; if (bus_if.hi !== 32'h0000_1234) begin errors++; $display("FAIL mtlo_hi_kept: got %h want 00001234", bus_if.hi); end
        cyc();
        checks++; if (bus_if.done !== 1'b0) begin errors++; $display("FAIL mtlo_done_pulse: got %b want 0", bus_if.done); end
    endtask

    task automatic test_start_while_busy();
        int n, nb;
        issue(OP_DIVU, 32'd100, 32'd7);
        for (int i = 0; i < 4; i++) cyc();
        bus_if.op    = OP_MULTU;
        bus_if.a     = 32'd3;
        bus_if.b     = 32'd3;
        bus_if.start = 1'b1;
        cyc();
        bus_if.start = 1'b0;
        run_to_done(n, nb);
        checks++; if (n + 5 !== 33) begin errors++; $display("FAIL busy_start_latency: got %0d want 33", n + 5); end
        checks++; if (bus_if.lo !== 32'd14) begin errors++; $display("FAIL busy_start_lo: got %0d want 14", bus_if.lo); end
        checks++; if (bus_if.hi !== 32'd2) begin errors++; $display("FAIL busy_start_hi: got %0d want 2", bus_if.hi); end
        cyc();
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL busy_start_idle: got %b want 0", bus_if.busy); end
    endtask

    task automatic test_flush();
        int seen_done;
        issue(OP_MULT, 32'd3, 32'd4);
        for (int i = 0; i < 9; i++) cyc();
        bus_if.flush = 1'b1;
        cyc();
        bus_if.flush = 1'b0;
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL flush_busy: got %b want 0", bus_if.busy); end
        seen_done = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus_if.done) seen_done++;
            cyc();
        end
        checks++; if (seen_done !== 0) begin errors++; $display("FAIL flush_no_done: got %0d pulses want 0", seen_done); end
        checks++; if (bus_if.hi !== 32'd2) begin errors++; $display("FAIL flush_hi_kept: got %h want 2", bus_if.hi); end
        checks++; if (bus_if.lo !== 32'd14) begin errors++; $display("FAIL flush_lo_kept: got %h want e", bus_if.lo); end
        // flush together with start in IDLE drops the request
        bus_if.flush = 1'b1;
        issue(OP_MULTU, 32'd6, 32'd7);
        bus_if.flush = 1'b0;
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL flush_start_busy: got %b want 0", bus_if.busy); end
        checks++; if (bus_if.done !== 1'b0) begin errors++; $display("FAIL flush_start_done: got %b want 0", bus_if.done); end
    endtask

    task automatic test_reset_mid_and_back_to_back();
        int n, nb;
        issue(OP_MULT, 32'd3, 32'd4);
        for (int i = 0; i < 9; i++) cyc();
        reset = 1'b0;
        cyc();
        reset = 1'b1;
        checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", bus_if.busy); end
        checks++; if (bus_if.hi !== 32'h0) begin errors++; $display("FAIL midreset_hi: got %h want 0", bus_if.hi); end
        checks++; if (bus_if.lo !== 32'h0) begin errors++; $display("FAIL midreset_lo: got %h want 0", bus_if.lo); end
        issue(OP_MULTU, 32'd6, 32'd7);
        run_to_done(n, nb);
        checks++; if (bus_if.lo !== 32'd42) begin errors++; $display("FAIL b2b_first_lo: got %0d want 42", bus_if.lo); end
        bus_if.op    = OP_DIVU;
        bus_if.a     = 32'd50;
        bus_if.b     = 32'd8;
        bus_if.start = 1'b1;
        cyc();
        bus_if.start = 1'b0;
        checks++; if (bus_if.done !== 1'b0) begin errors++; $display("FAIL b2b_done_gap: got %b want 0", bus_if.done); end
        run_to_done(n, nb);
        checks++; if (n !== 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", n); end
        checks++; if (bus_if.lo !== 32'd6) begin errors++; $display("FAIL b2b_second_lo: got %0d want 6", bus_if.lo); end
        checks++; if (bus_if.hi !== 32'd2) begin errors++; $display("FAIL b2b_second_hi: got %0d want 2", bus_if.hi); end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        reset        = 1'b0;
        bus_if.start = 1'b0;
        bus_if.op    = OP_MULT;
        bus_if.a     = '0;
        bus_if.b     = '0;
        bus_if.flush = 1'b0;
        #1;
        test_reset();
        test_multu_latency();
        test_signed();
        test_div_edges();
        test_mthi_mtlo();
        test_start_while_busy();
        test_flush();
        test_reset_mid_and_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mips_muldiv.md
Name: mips_muldiv

Overview:
- Iterative multiply/divide unit with architectural HI/LO registers, driven from the decode stage.
- Successor to the single-cycle combinational ALU: width-parametrised, multi-cycle, with a start/busy/done handshake.
- Adds the mult/multu/div/divu/mthi/mtlo modes that the add-only ALU lacks.
- Sits beside the ALU in the datapath; the control FSM stalls while busy is high.

Parameters:
- WIDTH, 32, operand/HI/LO width; legal values ≥ 4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, never overridden.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- start  in  1  operation request; accepted only when busy=0
- op  in  3  operation code (encodings in package)
- a  in  WIDTH  rs operand: multiplicand, dividend, or mthi/mtlo source
- b  in  WIDTH  rt operand: multiplier or divisor
- flush  in  1  cancel the in-flight operation (exception/branch squash)
- busy  out  1  iterative operation in progress
- done  out  1  one-cycle pulse; HI/LO updated
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset (reset=0 at a rising edge) has priority over everything. It forces IDLE, busy=0, done=0, hi=0, lo=0 and the counter to 0. This applies mid-operation: partial results are discarded.
- States: IDLE, CALC, FIX.
- IDLE with start=1 and op in {MULT, MULTU, DIV, DIVU}:
  - latch |a| and |b| (signed ops) or raw values (unsigned ops);
  - latch sign flags: negP = a[W-1]^b[W-1], negR = a[W-1];
  - clear the counter and go to CALC; busy=1 from the next cycle.
- IDLE with start=1 and op in {MTHI, MTLO}:
  - write a into hi or lo at that edge;
  - done=1 for the following cycle; busy stays 0.
- Reserved op with start=1: ignored, no state change, no done.
- CALC runs exactly WIDTH cycles (counter 0..WIDTH-1):
  - multiply: radix-2 shift-add into a 2·WIDTH accumulator;
  - divide: restoring shift-subtract, producing one quotient bit per cycle.
- After the last CALC cycle, go to FIX (1 cycle). FIX:
  - applies sign correction: product negated if negP; quotient negated if negP; remainder negated if negR;
  - writes hi/lo: mult → hi = upper half, lo = lower half; div → lo = quotient, hi = remainder;
  - returns to IDLE; done=1 and busy=0 in the cycle after FIX.
- Latency: start at edge E0; busy high for WIDTH+1 cycles; done and new hi/lo visible after edge E(W+1).
- hi/lo hold their old values throughout CALC and FIX. They change only on a FIX write, mthi/mtlo, or reset.
- start while busy=1 is ignored; the operation in flight is unaffected.
- flush=1 while busy=1: return to IDLE at that edge, busy=0, no done, hi/lo unchanged. flush in IDLE has no effect. flush and start in the same IDLE cycle: flush wins and start is dropped.
- Divide by zero (signed or unsigned): lo = all-ones, hi = a. Takes the normal WIDTH+1 latency, no trap.
- Signed MIN / −1: lo = MIN, hi = 0. This falls out of the abs/negate scheme with no special case.
- Width rules: all arithmetic is unsigned on magnitudes. The accumulator is 2·WIDTH bits; the divide remainder path is WIDTH+1 bits to hold the subtract borrow.
- done is a strict single-cycle pulse; back-to-back operations give distinct pulses.

Decomposition:
- Shared package mips_pkg:
  - op localparams: OP_MULT=3'b000, OP_MULTU=3'b001, OP_DIV=3'b010, OP_DIVU=3'b011, OP_MTHI=3'b100, OP_MTLO=3'b101, 3'b110/3'b111 reserved;
  - state encoding: S_IDLE, S_CALC, S_FIX.
- One sub-module: muldiv_negate (WIDTH-parametrised conditional two's-complement). It is reused for operand abs and result sign fix.
- FSM, counter and datapath live in mips_muldiv.

Test Plan (WIDTH=32):
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → done exactly 33 cycles after start; hi=0xFFFFFFFE, lo=0x00000001; busy high 33 cycles.
- MULT a=−3, b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1. DIV a=−7, b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=7, b=0 → lo=0xFFFFFFFF, hi=0x00000007. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- MTHI a=0x1234 then MTLO a=0x5678 on consecutive cycles → each gives a 1-cycle done with busy=0; hi=0x1234, lo=0x5678.
- Start DIVU 100/7; pulse start with MULTU at cycle 5 → second request ignored; result lo=14, hi=2.
- Start MULT, then flush at cycle 10 → busy drops next cycle, no done, hi/lo keep prior values. Repeat with reset=0 at cycle 10 instead → hi=lo=0, busy=0.
